// File: rtl/rpn_pkg.sv
// Shared types for the RPN stack calculator: FSM states, opcodes, error codes
// and flag bit positions.
package rpn_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPush  = 3'd1,
    StExec  = 3'd2,
    StWrite = 3'd3,
    StError = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpSwap = 3'd4,
    OpDrop = 3'd5,
    OpClr  = 3'd6,
    OpDup  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ErrNone      = 2'b00,
    ErrOverflow  = 2'b01,
    ErrUnderflow = 2'b10
  } err_e;

  // Flags are presented as {N,Z,C,V}
  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

endpackage

// File: rtl/rpn_alu.sv
// Combinational ALU for the two-operand opcodes: ADD, SUB, AND, OR.
// A is the entry below top, B is top; flags are {N,Z,C,V}.
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           ovf;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the unsigned borrow (a < b)
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      2'd0: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      2'd1: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      2'd2: result = a & b;
      2'd3: result = a | b;
      default: result = '0;
    endcase
  end

  always_comb begin
    flags        = '0;
    flags[FlagN] = result[WIDTH-1];
    flags[FlagZ] = (result == '0);
    flags[FlagC] = carry;
    flags[FlagV] = ovf;
  end

endmodule

// File: rtl/rpn_stack_calculator.sv
// Reverse-Polish calculator: command FSM, input latch, register-array operand
// stack with entry count, and a result register between ALU and commit.
module rpn_stack_calculator
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Enter,
  input  logic                         IsOp,
  input  logic [WIDTH-1:0]             DataIn,
  output logic [WIDTH-1:0]             Top,
  output logic [$clog2(DEPTH+1)-1:0]   Depth,
  output logic [3:0]                   Flags,
  output logic [1:0]                   ErrCode,
  output logic                         Ready,
  output logic [2:0]                   CurrentState
);

  localparam int unsigned   CntW = $clog2(DEPTH + 1);
  localparam int unsigned   IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic              accept;
  logic [WIDTH-1:0]  cmd_q;
  logic [WIDTH-1:0]  stack_q [DEPTH];
  logic [CntW-1:0]   count_q;
  logic [WIDTH-1:0]  result_q;
  logic [3:0]        res_flags_q;
  logic [3:0]        flags_q;

  opcode_e           in_op, cmd_op;
  logic [IdxW-1:0]   idx_push, idx_a, idx_b;
  logic [WIDTH-1:0]  opnd_a, opnd_b;
  logic [WIDTH-1:0]  alu_result;
  logic [3:0]        alu_flags;

  assign in_op    = opcode_e'(DataIn[2:0]);
  assign cmd_op   = opcode_e'(cmd_q[2:0]);
  assign idx_push = IdxW'(count_q);
  assign idx_b    = IdxW'(count_q - CntW'(1));
  assign idx_a    = IdxW'(count_q - CntW'(2));

  // Reads are gated by count so empty slots never reach Top or the ALU
  always_comb begin
    opnd_a = '0;
    opnd_b = '0;
    if (count_q != '0)        opnd_b = stack_q[idx_b];
    if (count_q >= CntW'(2))  opnd_a = stack_q[idx_a];
  end

  rpn_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (opnd_a),
    .b      (opnd_b),
    .op     (cmd_q[1:0]),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Enter) begin
          accept = 1'b1;
          if (!IsOp) begin
            if (count_q == Full) begin
              state_d = StError;
              err_d   = ErrOverflow;
            end else begin
              state_d = StPush;
            end
          end else if (in_op == OpClr) begin
            state_d = StExec;
          end else if (in_op == OpDup && count_q == Full) begin
            state_d = StError;
            err_d   = ErrOverflow;
          end else if ((in_op == OpDrop || in_op == OpDup) ? (count_q == '0)
                                                           : (count_q < CntW'(2))) begin
            state_d = StError;
            err_d   = ErrUnderflow;
          end else begin
            state_d = StExec;
          end
        end
      end
      StPush:  state_d = StIdle;
      StExec:  state_d = StWrite;
      StWrite: begin
        state_d = StIdle;
        if (cmd_op == OpClr) err_d = ErrNone;
      end
      StError: begin
        if (Enter && IsOp && in_op == OpClr) begin
          accept  = 1'b1;
          state_d = StExec;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      err_q       <= ErrNone;
      cmd_q       <= '0;
      count_q     <= '0;
      result_q    <= '0;
      res_flags_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) cmd_q <= DataIn;
      unique case (state_q)
        StPush: count_q <= count_q + CntW'(1);
        StExec: begin
          result_q    <= alu_result;
          res_flags_q <= alu_flags;
        end
        StWrite: begin
          unique case (cmd_op)
            OpAdd, OpSub, OpAnd, OpOr: begin
              count_q <= count_q - CntW'(1);
              flags_q <= res_flags_q;
            end
            OpSwap: ;
            OpDrop: count_q <= count_q - CntW'(1);
            OpClr:  count_q <= '0;
            OpDup:  count_q <= count_q + CntW'(1);
          endcase
        end
        default: ;
      endcase
    end
  end

  // Stack storage has no reset; slots at or above count are don't-care
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StPush) begin
        stack_q[idx_push] <= cmd_q;
      end else if (state_q == StWrite) begin
        unique case (cmd_op)
          OpAdd, OpSub, OpAnd, OpOr: stack_q[idx_a] <= result_q;
          OpSwap: begin
            stack_q[idx_a] <= opnd_b;
            stack_q[idx_b] <= opnd_a;
          end
          OpDup:  stack_q[idx_push] <= opnd_b;
          default: ;
        endcase
      end
    end
  end

  assign Top          = opnd_b;
  assign Depth        = count_q;
  assign Flags        = flags_q;
  assign ErrCode      = err_q;
  assign Ready        = (state_q == StIdle);
  assign CurrentState = state_q;

endmodule

// File: tb/tb_rpn_stack_calculator.sv
// Self-checking bench for rpn_stack_calculator: directed test-plan steps then
// random commands, all checked against a queue-based reference model.
module tb_rpn_stack_calculator;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int DW = $clog2(D + 1);
  localparam longint Mod  = longint'(1) << W;
  localparam longint Half = longint'(1) << (W - 1);

  localparam int SIdle = 0, SPush = 1, SExec = 2, SWrite = 3, SError = 4;

  logic          clk = 1'b0;
  logic          reset, Enter, IsOp;
  logic [W-1:0]  DataIn;
  logic [W-1:0]  Top;
  logic [DW-1:0] Depth;
  logic [3:0]    Flags;
  logic [1:0]    ErrCode;
  logic          Ready;
  logic [2:0]    CurrentState;

  rpn_stack_calculator #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Enter        (Enter),
    .IsOp         (IsOp),
    .DataIn       (DataIn),
    .Top          (Top),
    .Depth        (Depth),
    .Flags        (Flags),
    .ErrCode      (ErrCode),
    .Ready        (Ready),
    .CurrentState (CurrentState)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] stk[$];
  logic [3:0]   m_flags;
  logic [1:0]   m_err;
  bit           m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_flags = 4'b0000;
    m_err   = 2'b00;
    m_fault = 1'b0;
  endtask

  function automatic longint as_signed(input longint v);
    return (v >= Half) ? v - Mod : v;
  endfunction

  // Predicts the state right after the accepting edge and the extra cycles to settle
  task automatic model_step(input bit isop, input logic [W-1:0] d, output int nxt,
                            output int lat);
    int     op;
    int     n;
    longint a, b, r, sr;
    bit     c, v;
    op = int'(d[2:0]);
    n  = stk.size();
    if (m_fault) begin
      if (isop && op == 6) begin
        stk.delete();
        m_err = 2'b00; m_fault = 1'b0; nxt = SExec; lat = 2;
      end else begin
        nxt = SError; lat = 0;
      end
      return;
    end
    if (!isop) begin
      if (n == D) begin
        m_err = 2'b01; m_fault = 1'b1; nxt = SError; lat = 0;
      end else begin
        stk.push_back(d); nxt = SPush; lat = 1;
      end
      return;
    end
    if ((op == 7 && n == D)) begin
      m_err = 2'b01; m_fault = 1'b1; nxt = SError; lat = 0; return;
    end
    if ((op <= 4 && n < 2) || ((op == 5 || op == 7) && n == 0)) begin
      m_err = 2'b10; m_fault = 1'b1; nxt = SError; lat = 0; return;
    end
    nxt = SExec; lat = 2;
    case (op)
      0, 1, 2, 3: begin
        b = longint'(stk.pop_back());
        a = longint'(stk.pop_back());
        c = 0; v = 0;
        if (op == 0) begin
          r  = (a + b) % Mod;
          c  = (a + b) >= Mod;
          sr = as_signed(a) + as_signed(b);
          v  = (sr >= Half) || (sr < -Half);
        end else if (op == 1) begin
          r  = (a - b + Mod) % Mod;
          c  = a < b;
          sr = as_signed(a) - as_signed(b);
          v  = (sr >= Half) || (sr < -Half);
        end else if (op == 2) begin
          r = a & b;
        end else begin
          r = a | b;
        end
        stk.push_back(W'(r));
        m_flags = {r >= Half, r == 0, c, v};
      end
      4: begin
        b = longint'(stk.pop_back());
        a = longint'(stk.pop_back());
        stk.push_back(W'(b));
        stk.push_back(W'(a));
      end
      5: void'(stk.pop_back());
      6: begin stk.delete(); m_err = 2'b00; end
      default: stk.push_back(stk[$]);
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_top"},   Top,     (stk.size() > 0) ? 32'(stk[$]) : 32'd0);
    chk({tag, "_depth"}, Depth,   32'(stk.size()));
    chk({tag, "_flags"}, Flags,   m_flags);
    chk({tag, "_err"},   ErrCode, m_err);
    chk({tag, "_ready"}, Ready,   m_fault ? 32'd0 : 32'd1);
    chk({tag, "_state"}, CurrentState, m_fault ? SError : SIdle);
  endtask

  task automatic issue(input bit isop, input logic [W-1:0] d, input string tag);
    int nxt, lat, waited, n0;
    n0 = stk.size();
    model_step(isop, d, nxt, lat);
    @(negedge clk);
    Enter = 1'b1; IsOp = isop; DataIn = d;
    @(negedge clk);
    Enter = 1'b0;
    chk({tag, "_state1"}, CurrentState, nxt);
    chk({tag, "_depth1"}, Depth, n0);
    waited = 0;
    while (!(Ready || CurrentState == 3'(SError)) && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_latency"}, waited, lat);
    check_all(tag);
  endtask

  task automatic push(input logic [W-1:0] d);
    issue(1'b0, d, "push");
  endtask

  task automatic op(input int o);
    issue(1'b1, W'(o), "op");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    Enter = 1'b0; IsOp = 1'b0; DataIn = '0; reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all("reset");

    // 5 + 3
    push(5); push(3); op(0);
    chk("plan1_top", Top, 32'h8); chk("plan1_flags", Flags, 4'b0000);
    op(6);

    // 3 - 5 borrows and goes negative
    push(3); push(5); op(1);
    chk("plan2_top", Top, 32'hFFFE); chk("plan2_flags", Flags, 4'b1010);
    op(6);

    // signed overflow, then AND clears C/V
    push(16'h7FFF); push(16'h0001); op(0);
    chk("plan3_top", Top, 32'h8000); chk("plan3_flags", Flags, 4'b1001);
    push(16'h8000); op(2);
    chk("plan3_and_top", Top, 32'h8000); chk("plan3_and_flags", Flags, 4'b1000);
    op(6);

    // overflow on fifth push, extra push ignored, CLR recovers
    push(1); push(2); push(3); push(4); push(5);
    chk("plan4_err", ErrCode, 2'b01); chk("plan4_depth", Depth, 4); chk("plan4_top", Top, 4);
    push(6);
    op(6);
    chk("plan4_clr_depth", Depth, 0); chk("plan4_clr_ready", Ready, 1'b1);

    // underflow, recovery, stack manipulation
    push(7); op(0);
    chk("plan5_err", ErrCode, 2'b10); chk("plan5_top", Top, 7);
    op(6);
    push(1); push(2); op(4);
    chk("plan5_swap_top", Top, 1);
    op(7);
    chk("plan5_dup_depth", Depth, 3); chk("plan5_dup_top", Top, 1);
    op(5);
    chk("plan5_drop_depth", Depth, 2);
    op(6);

    // reset asserted during S_WRITE discards the commit
    push(5); push(3);
    @(negedge clk); Enter = 1'b1; IsOp = 1'b1; DataIn = W'(0);
    @(negedge clk); Enter = 1'b0;
    chk("rstmid_exec", CurrentState, SExec);
    @(negedge clk);
    chk("rstmid_write", CurrentState, SWrite);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
    check_all("rstmid");

    // reset wins over a simultaneous Enter
    push(1);
    @(negedge clk); reset = 1'b1; Enter = 1'b1; IsOp = 1'b0; DataIn = W'(9);
    @(negedge clk); reset = 1'b0; Enter = 1'b0;
    model_reset();
    check_all("rst_enter");
    @(negedge clk);
    check_all("rst_enter_later");

    // Enter held into S_PUSH: second cycle dropped
    @(negedge clk); Enter = 1'b1; IsOp = 1'b0; DataIn = W'(9);
    @(negedge clk); DataIn = W'(10);
    @(negedge clk); Enter = 1'b0;
    stk.push_back(W'(9));
    check_all("held_enter");
    op(6);

    // random commands against the model
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 9) < 5) begin
        case ($urandom_range(0, 5))
          0: d = '0;
          1: d = W'(16'h7FFF);
          2: d = W'(16'h8000);
          3: d = '1;
          default: d = W'($urandom);
        endcase
        push(d);
      end else begin
        op(int'($urandom_range(0, 7)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
